updown_counter_sched: RTL
=========================

Name: updown_counter_sched

Overview:
- Two-requester scheduler for the shared 3-bit synchronous up/down counter.
- Arbitrates counter ownership round-robin. Drives the counter's direction (M) and count enable for the granted requester's step count. Reports completion and wrap events.
- Sits between requester logic and the counter. The counter's clock enable is gated by En at the system level. The counter shares Clk and Clr with this block.

Parameters:
- CNT_W, 3, width of counter value Q observed for wrap detection.
- STEP_W, 3, width of each step-count request (0 to 2^STEP_W-1 steps).

Ports:
- Clk  input  1  system clock, rising-edge.
- Clr  input  1  asynchronous active-low reset.
- Req  input  2  per-requester request level; Req[i] held until Done[i] is seen.
- Dir0  input  1  requester 0 direction: 0 = up, 1 = down.
- Steps0  input  STEP_W  requester 0 step count.
- Dir1  input  1  requester 1 direction.
- Steps1  input  STEP_W  requester 1 step count.
- Q  input  CNT_W  current counter value.
- M  output  1  counter mode: 0 = up, 1 = down.
- En  output  1  counter count enable; the counter steps on each rising Clk edge where En = 1.
- Gnt  output  2  one-hot grant, owner of the counter.
- Done  output  2  one-cycle completion pulse to the owner.
- Busy  output  1  high whenever state is not IDLE.
- Wrap  output  1  one-cycle pulse after a 7->0 (up) or 0->7 (down) step.

Behaviour:
- Reset: Clr low asynchronously forces the following, regardless of the operation in progress:
  - state = IDLE;
  - M = 0, En = 0, Gnt = 00, Done = 00, Busy = 0, Wrap = 0;
  - remaining count = 0, round-robin pointer Last = 1, so requester 0 wins first.
- FSM states and outputs: IDLE, RUN, DONE. All outputs are decoded from registered state and registers; there is no combinational path from Req to any output.
- IDLE:
  - No Req: stay in IDLE.
  - Any Req: select the owner. A single requester wins. If both request, the requester != Last wins.
  - Latch the owner's Dir into dir_r and Steps into rem_r. Set Gnt[owner].
  - Next state is RUN if Steps != 0, else DONE.
- RUN:
  - En = 1, M = dir_r, Gnt held, Busy = 1.
  - rem_r decrements each cycle.
  - When rem_r == 1, this is the last En cycle; next state is DONE.
  - Exactly Steps En cycles occur per grant.
- DONE:
  - En = 0, Done[owner] = 1 for one cycle, Gnt held this cycle.
  - Last <= owner. Next state is IDLE with Gnt = 00.
- Latency: Req sampled in IDLE at edge e0. En is high for cycles e0+1 .. e0+N; Done is high in cycle e0+N+1.
  - Steps = 0: no En cycles; Done is high in cycle e0+1.
- Requester rule:
  - Req is deasserted at the edge at which Done was high.
  - Req still high in the following IDLE cycle is a new request.
  - Dir and Steps are don't-care outside the request edge.
- M while not in RUN: holds dir_r. En = 0 guarantees no counter motion.
- Wrap:
  - At an edge with En = 1 and ((M = 0 and Q = all-ones) or (M = 1 and Q = 0)), Wrap <= 1 for the next cycle.
  - Otherwise Wrap <= 0.
  - Consecutive wraps give consecutive pulses.
- Simultaneous events:
  - Req changes during RUN or DONE are ignored.
  - The non-owner's request waits and is served at the next IDLE.
  - Guaranteed alternation: a waiting request is served before the just-finished owner's next request.

Test Plan:
- Reset, Q = 0; Req = 01, Dir0 = 0, Steps0 = 3 -> Gnt = 01, En high 3 cycles, M = 0, Q 0->3, Done = 01 one cycle, Busy low after.
- Q = 2; Req = 10, Dir1 = 1, Steps1 = 5 -> M = 1, Q 2,1,0,7,6,5, Wrap pulse once, in the cycle after the 0->7 step; Done = 10.
- Both Req asserted together after reset, Steps0 = 2, Steps1 = 1 -> requester 0 first (2 En), then requester 1 (1 En); Gnt never 11; Done order 01 then 10.
- Requester 0 re-requests immediately while requester 1 waits -> requester 1 granted next (round-robin).
- Steps0 = 0 -> no En; Done = 01 in the cycle after the request edge; Q unchanged.
- Clr pulsed low mid-RUN (Steps = 7, after 3 steps) -> all outputs 0 immediately, state IDLE. After release, simultaneous Req grants requester 0.

Source files
------------

// File: rtl/updown_counter_sched_if.sv
// Signal bundle between requester logic / shared counter and the up/down counter scheduler.
// The scheduler takes the slave view; requesters and the counter model take the master view.
interface updown_counter_sched_if #(
    parameter int CNT_W  = 3,
    parameter int STEP_W = 3
);
    logic [1:0]        Req;
    logic              Dir0;
    logic [STEP_W-1:0] Steps0;
    logic              Dir1;
    logic [STEP_W-1:0] Steps1;
    logic [CNT_W-1:0]  Q;
    logic              M;
    logic              En;
    logic [1:0]        Gnt;
    logic [1:0]        Done;
    logic              Busy;
    logic              Wrap;

    modport master (
        output Req, Dir0, Steps0, Dir1, Steps1, Q,
        input  M, En, Gnt, Done, Busy, Wrap
    );

    modport slave (
        input  Req, Dir0, Steps0, Dir1, Steps1, Q,
        output M, En, Gnt, Done, Busy, Wrap
    );
endinterface

// File: rtl/updown_counter_sched.sv
// Round-robin scheduler granting two requesters ownership of a shared up/down counter.
// Every output is a register, so no combinational path exists from Req to any output.
module updown_counter_sched #(
    parameter int CNT_W  = 3,
    parameter int STEP_W = 3
) (
    input logic                   Clk,
    input logic                   Clr,
    updown_counter_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};

    state_t            state_r, state_nx_s;
    logic              owner_r, owner_nx_s;
    logic              last_r, last_nx_s;
    logic              dir_r, dir_nx_s;
    logic [STEP_W-1:0] rem_r, rem_nx_s;
    logic              en_r, busy_r, wrap_r, wrap_nx_s;
    logic [1:0]        gnt_r, done_r;

    function automatic logic [1:0] onehot2(input logic idx);
        onehot2 = idx ? 2'b10 : 2'b01;
    endfunction

    // Next-state logic: arbitration in IDLE, step countdown in RUN, pointer update in DONE
    always_comb begin
        state_nx_s = state_r;
        owner_nx_s = owner_r;
        last_nx_s  = last_r;
        dir_nx_s   = dir_r;
        rem_nx_s   = rem_r;
        case (state_r)
            IDLE: begin
                if (bus.Req != 2'b00) begin
                    // With both requesting, whoever did not own last goes first
                    if (bus.Req == 2'b11) begin
                        owner_nx_s = ~last_r;
                    end else begin
                        owner_nx_s = bus.Req[1];
                    end
                    if (owner_nx_s) begin
                        dir_nx_s = bus.Dir1;
                        rem_nx_s = bus.Steps1;
                    end else begin
                        dir_nx_s = bus.Dir0;
                        rem_nx_s = bus.Steps0;
                    end
                    if (rem_nx_s != STEP_ZERO) begin
                        state_nx_s = RUN;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                rem_nx_s = rem_r - STEP_ONE;
                if (rem_r == STEP_ONE) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                last_nx_s  = owner_r;
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Wrap is judged on the pre-step counter value at a stepping edge
    always_comb begin
        wrap_nx_s = en_r & ((~dir_r & (bus.Q == CNT_ONES)) | (dir_r & (bus.Q == CNT_ZERO)));
    end

    // State, datapath and output registers; outputs follow the next state
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            dir_r   <= 1'b0;
            rem_r   <= STEP_ZERO;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            wrap_r  <= 1'b0;
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
        end else begin
            state_r <= state_nx_s;
            owner_r <= owner_nx_s;
            last_r  <= last_nx_s;
            dir_r   <= dir_nx_s;
            rem_r   <= rem_nx_s;
            en_r    <= (state_nx_s == RUN);
            busy_r  <= (state_nx_s != IDLE);
            wrap_r  <= wrap_nx_s;
            gnt_r   <= (state_nx_s != IDLE) ? onehot2(owner_nx_s) : 2'b00;
            done_r  <= (state_nx_s == DONE) ? onehot2(owner_nx_s) : 2'b00;
        end
    end

    assign bus.M    = dir_r;
    assign bus.En   = en_r;
    assign bus.Gnt  = gnt_r;
    assign bus.Done = done_r;
    assign bus.Busy = busy_r;
    assign bus.Wrap = wrap_r;
endmodule
